// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive/transmit path.
//
// Contents:
//   SPI_WORD_W          width of one SPI word
//   SPI_FIFO_DEPTH_DEF  default word FIFO depth
//   SPI_CS_IDLE         idle (deasserted) level of chip select
//   spi_word_t          one SPI word
package spi_pkg;

    localparam int       SPI_WORD_W         = 16;
    localparam int       SPI_FIFO_DEPTH_DEF = 4;
    localparam logic     SPI_CS_IDLE        = 1'b1;

    typedef logic [SPI_WORD_W-1:0] spi_word_t;

endpackage : spi_pkg

// File: rtl/spi_word_fifo.sv
// Synchronous word FIFO. Shared by the SPI RX and TX paths.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  word width
// Ports:
//   clk    system clock, all flops on posedge
//   reset  synchronous active-high reset; empties the FIFO
//   push   write din (ignored when full unless pop in the same cycle)
//   pop    advance the read pointer (ignored when empty)
//   din    write data
//   dout   head entry, combinational from the read pointer
//   full   all DEPTH entries occupied
//   empty  no entries occupied
module spi_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer tells a full FIFO from an empty one when
    // the index bits match; pointers wrap modulo 2*DEPTH.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A push into a full FIFO is legal when a pop frees the head slot in the
    // same cycle; the head is read before the write lands.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: non-blocking assignments in clocked blocks, so every flop samples
    // the values present before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are
    // valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule : spi_word_fifo

// File: rtl/spi_frame_sync.sv
// Moves each 16-bit word received by spi_rx16 into the system clock domain.
// Chip select is double-flop synchronised; the end of a frame (CS rising) is
// detected only after a matching falling edge, the parallel word is captured
// on that edge and queued, and the core drains the queue via valid/ready.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2)
//   CNT_W      frame counter width (only with SPI_FRAME_CNT_EN)
// Ports:
//   clk        system clock, all flops on posedge
//   reset      synchronous active-high reset
//   spi_cs     raw asynchronous chip select
//   spi_data   spi_rx16 parallel word, stable while spi_cs is high
//   out_data   head-of-FIFO word; holds last value while out_valid is low
//   out_valid  FIFO not empty
//   out_ready  consumer accepts out_data when out_valid & out_ready
//   busy       synchronised CS is low (frame in progress)
//   overflow   sticky: a frame was dropped because the FIFO was full
//   ovf_clr    single-cycle pulse clearing overflow (a same-cycle drop wins)
//   frame_cnt  count of detected frames, wraps (only with SPI_FRAME_CNT_EN)
//
// Build option: define SPI_FRAME_CNT_EN to add the CNT_W parameter, the
// frame_cnt port and its counter.
module spi_frame_sync
    import spi_pkg::*;
#(
    parameter int DEPTH = SPI_FIFO_DEPTH_DEF
`ifdef SPI_FRAME_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_cs,
    input  logic [SPI_WORD_W-1:0] spi_data,
    output logic [SPI_WORD_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  ovf_clr
`ifdef SPI_FRAME_CNT_EN
    ,
    output logic [CNT_W-1:0]      frame_cnt
`endif
);

    logic      cs_s1;
    logic      cs_s2;
    logic      cs_d;
    // Marks which CS pipeline stages hold real samples since reset. The
    // synchroniser resets to idle, so a CS already low at reset release
    // would otherwise look like a fresh falling edge.
    logic [2:0] cs_live;
    logic      fall;
    logic      rise;
    logic      armed;

    logic      rise_q;
    spi_word_t word_q;
    spi_word_t hold_q;
    spi_word_t fifo_dout;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      push;
    logic      drop;

    // ---------------------------------------------------------------- CS sync
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_s1   <= SPI_CS_IDLE;
            cs_s2   <= SPI_CS_IDLE;
            cs_d    <= SPI_CS_IDLE;
            cs_live <= '0;
        end else begin
            cs_s1   <= spi_cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            cs_live <= {cs_live[1:0], 1'b1};
        end
    end

    assign fall = ~cs_s2 & cs_d & cs_live[2];
    assign rise = cs_s2 & ~cs_d & armed;
    assign busy = ~cs_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
        end else if (fall) begin
            armed <= 1'b1;
        end else if (rise) begin
            armed <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- capture
    // spi_data is quiescent while CS is high, so it is registered directly on
    // the detected rise; the push then happens on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            word_q <= '0;
        end else begin
            rise_q <= rise;
            if (rise) word_q <= spi_data;
        end
    end

    // ------------------------------------------------------------ push / drop
    assign pop = out_valid & out_ready;

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        push = 1'b0;
        drop = 1'b0;
        if (rise_q) begin
            if (~fifo_full | pop) push = 1'b1;
            else                  drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    spi_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SPI_WORD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (word_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------ output side
    // Remember the last word handed over so out_data stays put (and reads 0
    // after reset) while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else if (pop) begin
            hold_q <= fifo_dout;
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? hold_q : fifo_dout;

`ifdef SPI_FRAME_CNT_EN
    // Counts every detected frame end, whether its word was kept or dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (rise) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule : spi_frame_sync

// File: tb/tb_spi_frame_sync.sv
// Scoreboard bench for spi_frame_sync: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every accepted handshake.
module tb_spi_frame_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs;
    logic [15:0] spi_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overflow;
    logic        ovf_clr;
`ifdef SPI_FRAME_CNT_EN
    logic [1:0]  frame_cnt;
`endif

    int          passed = 0;
    int          total  = 0;
    int          pop_count = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

`ifdef SPI_FRAME_CNT_EN
    spi_frame_sync #(.DEPTH(4), .CNT_W(2)) dut (
`else
    spi_frame_sync #(.DEPTH(4)) dut (
`endif
        .clk       (clk),
        .reset     (reset),
        .spi_cs    (spi_cs),
        .spi_data  (spi_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
`ifdef SPI_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            pop_count++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL mon_unexpected: got %h, expected no word", out_data);
            end else begin
                check("mon_word", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All inputs change 1 time unit after a rising edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_low(input int n);
        cycles(1);
        spi_cs = 1'b0;
        cycles(n);
    endtask

    // Full frame: CS low, word set up, CS high, then idle high time.
    task automatic send_frame(input logic [15:0] word, input bit accepted);
        frame_low(8);
        spi_data = word;
        if (accepted) exp_q.push_back(word);
        spi_cs = 1'b1;
        cycles(6);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cycles(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int          n;
        int          pops_before;
        bit          seen;
        logic [15:0] words2 [4] = '{16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF};
        logic [15:0] words3 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        reset     = 1'b1;
        spi_cs    = 1'b1;
        spi_data  = 16'h0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        cycles(3);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_busy",      busy,      0);
        check("rst_overflow",  overflow,  0);
        reset = 1'b0;
        cycles(4);

        // 1: single frame, latency and one-cycle valid pulse
        out_ready = 1'b1;
        frame_low(4);
        check("t1_busy", busy, 1);
        cycles(12);
        spi_data = 16'hA55A;
        exp_q.push_back(16'hA55A);
        spi_cs = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            cycles(1);
            n++;
            seen = out_valid;
        end
        check("t1_latency_3_4", (n >= 3 && n <= 4), 1);
        cycles(1);
        check("t1_valid_pulse", out_valid, 0);
        check("t1_hold_data", out_data, 16'hA55A);
        cycles(4);
        wait_drain("t1_drain");

        // 2: four frames queued, then drained in order
        out_ready = 1'b0;
        foreach (words2[i]) send_frame(words2[i], 1'b1);
        check("t2_valid", out_valid, 1);
        check("t2_overflow", overflow, 0);
        out_ready = 1'b1;
        wait_drain("t2_drain");
        check("t2_overflow_end", overflow, 0);

        // 3: fifth frame into a full FIFO is dropped and flagged
        out_ready = 1'b0;
        foreach (words3[i]) send_frame(words3[i], 1'b1);
        check("t3_no_ovf_at_4", overflow, 0);
        send_frame(16'h1001, 1'b0);
        check("t3_overflow_set", overflow, 1);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        check("t3_overflow_clr", overflow, 0);

        // 4: FIFO still full; next push coincides with a single pop
        frame_low(8);
        spi_data = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        spi_cs = 1'b1;
        cycles(3);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
        cycles(4);
        check("t4_overflow", overflow, 0);
        check("t4_valid", out_valid, 1);
        pops_before = pop_count;
        out_ready = 1'b1;
        wait_drain("t4_drain");
        cycles(4);
        check("t4_occupancy_4", pop_count - pops_before, 4);
        check("t4_empty", out_valid, 0);

        // 5: reset mid-frame, interrupted frame yields nothing
        pops_before = pop_count;
        frame_low(5);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(8);
        spi_data = 16'hDEAD;
        spi_cs = 1'b1;
        cycles(8);
        check("t5_no_word", pop_count - pops_before, 0);
        check("t5_overflow", overflow, 0);
        send_frame(16'h0001, 1'b1);
        wait_drain("t5_drain");

`ifdef SPI_FRAME_CNT_EN
        // 6: frame counter wraps at 2^CNT_W
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(4);
        check("t6_cnt_rst", frame_cnt, 0);
        for (int i = 1; i <= 5; i++) begin
            send_frame(16'(i * 16'h0101), 1'b1);
            check("t6_frame_cnt", frame_cnt, i % 4);
        end
        wait_drain("t6_drain");
`endif

        cycles(4);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_spi_frame_sync
